// File: rtl/hit_life_manager.sv
// hit_life_manager: converts collision pulses into lives, score,
// invulnerability window and overall play state for Bumpy.
module hit_life_manager #(
  parameter int unsigned START_LIVES   = 3,
  parameter int unsigned GIFT_POINTS   = 10,
  parameter int unsigned SCORE_MAX     = 999,
  parameter int unsigned INVULN_FRAMES = 60,
  parameter int unsigned BLINK_BIT     = 2
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       SingleHitPulse,
  input  logic       giftHit,
  input  logic       startKey,
  output logic [2:0] lives,
  output logic [9:0] score,
  output logic [1:0] gameState,
  output logic       freeze,
  output logic       blink,
  output logic       lifeLostPulse,
  output logic       giftPulse
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PLAY   = 2'd1,
    S_INVULN = 2'd2,
    S_OVER   = 2'd3
  } state_t;

  localparam logic [2:0]  LIVES_INIT = 3'(START_LIVES);
  localparam logic [10:0] GIFT_ADD   = 11'(GIFT_POINTS);
  localparam logic [10:0] SMAX       = 11'(SCORE_MAX);
  localparam logic [7:0]  INV_INIT   = 8'(INVULN_FRAMES);

  state_t     state_q, state_d;
  logic [2:0] lives_q, lives_d;
  logic [9:0] score_q, score_d;
  logic [7:0] inv_cnt_q, inv_cnt_d;
  logic       freeze_q, freeze_d;
  logic       blink_q, blink_d;
  logic       lost_q, lost_d;
  logic       gift_q, gift_d;

  logic [10:0] score_sum;
  logic [9:0]  score_gift;
  logic        gift_ev;
  logic        haz_ev;

  // Saturating gift score, wide enough that the sum never wraps.
  always_comb begin
    score_sum  = {1'b0, score_q} + GIFT_ADD;
    score_gift = (score_sum > SMAX) ? SMAX[9:0] : score_sum[9:0];
    gift_ev    = SingleHitPulse & giftHit;
    haz_ev     = SingleHitPulse & ~giftHit;
  end

  // Next-state and registered-output logic for the play state machine.
  always_comb begin
    state_d   = state_q;
    lives_d   = lives_q;
    score_d   = score_q;
    inv_cnt_d = inv_cnt_q;
    lost_d    = 1'b0;
    gift_d    = 1'b0;
    unique case (state_q)
      S_IDLE, S_OVER: begin
        if (startKey) begin
          state_d = S_PLAY;
          lives_d = LIVES_INIT;
          score_d = '0;
        end
      end
      S_PLAY: begin
        if (gift_ev) begin
          score_d = score_gift;
          gift_d  = 1'b1;
        end else if (haz_ev) begin
          lost_d = 1'b1;
          if (lives_q <= 3'd1) begin
            lives_d = '0;
            state_d = S_OVER;
          end else begin
            lives_d   = lives_q - 3'd1;
            inv_cnt_d = INV_INIT;
            state_d   = S_INVULN;
          end
        end
      end
      S_INVULN: begin
        if (gift_ev) begin
          score_d = score_gift;
          gift_d  = 1'b1;
        end
        if (startOfFrame) begin
          inv_cnt_d = inv_cnt_q - 8'd1;
          if (inv_cnt_q <= 8'd1) begin
            inv_cnt_d = '0;
            state_d   = S_PLAY;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    freeze_d = (state_d == S_IDLE) || (state_d == S_OVER);
    blink_d  = (state_d == S_INVULN) ? inv_cnt_d[BLINK_BIT] : 1'b0;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q   <= S_IDLE;
      lives_q   <= LIVES_INIT;
      score_q   <= '0;
      inv_cnt_q <= '0;
      freeze_q  <= 1'b1;
      blink_q   <= 1'b0;
      lost_q    <= 1'b0;
      gift_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lives_q   <= lives_d;
      score_q   <= score_d;
      inv_cnt_q <= inv_cnt_d;
      freeze_q  <= freeze_d;
      blink_q   <= blink_d;
      lost_q    <= lost_d;
      gift_q    <= gift_d;
    end
  end

  assign lives         = lives_q;
  assign score         = score_q;
  assign gameState     = state_q;
  assign freeze        = freeze_q;
  assign blink         = blink_q;
  assign lifeLostPulse = lost_q;
  assign giftPulse     = gift_q;

endmodule

// File: tb/tb_hit_life_manager.sv
// tb_hit_life_manager: table vectors, directed corner sequences and
// random stimulus against a behavioural game model.
module tb_hit_life_manager;

  localparam int START_LIVES   = 3;
  localparam int GIFT_POINTS   = 10;
  localparam int SCORE_MAX     = 999;
  localparam int INVULN_FRAMES = 60;
  localparam int BLINK_BIT     = 2;

  logic       clk = 1'b0;
  logic       resetN;
  logic       startOfFrame, SingleHitPulse, giftHit, startKey;
  logic [2:0] lives;
  logic [9:0] score;
  logic [1:0] gameState;
  logic       freeze, blink, lifeLostPulse, giftPulse;

  int vectors = 0;
  int miscompares = 0;

  int m_st, m_lv, m_sc, m_inv, m_lp, m_gp;

  typedef struct {
    bit sof;
    bit hit;
    bit gift;
    bit start;
    int st;
    int lv;
    int sc;
  } vec_t;

  vec_t tbl [9];

  hit_life_manager #(
    .START_LIVES   (START_LIVES),
    .GIFT_POINTS   (GIFT_POINTS),
    .SCORE_MAX     (SCORE_MAX),
    .INVULN_FRAMES (INVULN_FRAMES),
    .BLINK_BIT     (BLINK_BIT)
  ) dut (
    .clk            (clk),
    .resetN         (resetN),
    .startOfFrame   (startOfFrame),
    .SingleHitPulse (SingleHitPulse),
    .giftHit        (giftHit),
    .startKey       (startKey),
    .lives          (lives),
    .score          (score),
    .gameState      (gameState),
    .freeze         (freeze),
    .blink          (blink),
    .lifeLostPulse  (lifeLostPulse),
    .giftPulse      (giftPulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_st = 0; m_lv = START_LIVES; m_sc = 0;
    m_inv = 0; m_lp = 0; m_gp = 0;
  endfunction

  function automatic void add_gift();
    m_sc = (m_sc + GIFT_POINTS > SCORE_MAX) ? SCORE_MAX : m_sc + GIFT_POINTS;
    m_gp = 1;
  endfunction

  // Game rules: 0 idle, 1 play, 2 invulnerable, 3 over.
  function automatic void model_step(bit sof, bit hit, bit gift, bit start);
    m_lp = 0;
    m_gp = 0;
    if (m_st == 0 || m_st == 3) begin
      if (start) begin
        m_st = 1; m_lv = START_LIVES; m_sc = 0;
      end
    end else if (m_st == 1) begin
      if (hit && gift) add_gift();
      else if (hit) begin
        m_lp = 1;
        m_lv = m_lv - 1;
        if (m_lv == 0) m_st = 3;
        else begin
          m_inv = INVULN_FRAMES;
          m_st = 2;
        end
      end
    end else begin
      if (hit && gift) add_gift();
      if (sof) begin
        m_inv = m_inv - 1;
        if (m_inv == 0) m_st = 1;
      end
    end
  endfunction

  task automatic check_model();
    int eb;
    eb = (m_st == 2) ? ((m_inv >> BLINK_BIT) & 1) : 0;
    chk("gameState", int'(gameState), m_st);
    chk("lives", int'(lives), m_lv);
    chk("score", int'(score), m_sc);
    chk("freeze", int'(freeze), (m_st == 0 || m_st == 3) ? 1 : 0);
    chk("blink", int'(blink), eb);
    chk("lifeLostPulse", int'(lifeLostPulse), m_lp);
    chk("giftPulse", int'(giftPulse), m_gp);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_state"}, int'(gameState), 0);
    chk({tag, "_lives"}, int'(lives), START_LIVES);
    chk({tag, "_score"}, int'(score), 0);
    chk({tag, "_freeze"}, int'(freeze), 1);
    chk({tag, "_blink"}, int'(blink), 0);
    chk({tag, "_lost"}, int'(lifeLostPulse), 0);
    chk({tag, "_giftp"}, int'(giftPulse), 0);
  endtask

  task automatic tick(input bit sof, input bit hit, input bit gift,
                      input bit start);
    startOfFrame   = sof;
    SingleHitPulse = hit;
    giftHit        = gift;
    startKey       = start;
    @(posedge clk);
    model_step(sof, hit, gift, start);
    #1;
    startOfFrame   = 1'b0;
    SingleHitPulse = 1'b0;
    giftHit        = 1'b0;
    startKey       = 1'b0;
    check_model();
  endtask

  task automatic mid_reset();
    #2;
    resetN = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    #1;
    resetN = 1'b1;
  endtask

  initial begin
    int n, gifts, frames;
    bit done;

    tbl[0] = '{0, 1, 1, 0, 0, 3, 0};
    tbl[1] = '{0, 1, 1, 1, 1, 3, 0};
    tbl[2] = '{0, 1, 1, 0, 1, 3, 10};
    tbl[3] = '{0, 1, 1, 0, 1, 3, 20};
    tbl[4] = '{0, 1, 0, 0, 2, 2, 20};
    tbl[5] = '{0, 1, 0, 0, 2, 2, 20};
    tbl[6] = '{1, 1, 1, 0, 2, 2, 30};
    tbl[7] = '{0, 0, 0, 1, 2, 2, 30};
    tbl[8] = '{1, 0, 0, 0, 2, 2, 30};

    resetN = 1'b0;
    startOfFrame = 1'b0;
    SingleHitPulse = 1'b0;
    giftHit = 1'b0;
    startKey = 1'b0;
    model_reset();
    #12;
    check_reset_outputs("reset");
    resetN = 1'b1;

    foreach (tbl[i]) begin
      tick(tbl[i].sof, tbl[i].hit, tbl[i].gift, tbl[i].start);
      chk($sformatf("tbl%0d_state", i), int'(gameState), tbl[i].st);
      chk($sformatf("tbl%0d_lives", i), int'(lives), tbl[i].lv);
      chk($sformatf("tbl%0d_score", i), int'(score), tbl[i].sc);
    end

    // Finish this window: 58 frames left, PLAY exactly on the last one.
    for (int i = 0; i < 58; i++) begin
      tick(1, 0, 0, 0);
      chk("inv_run_state", int'(gameState), (i == 57) ? 1 : 2);
    end

    // Second hazard: count frames (sof every other cycle) until PLAY.
    tick(0, 1, 0, 0);
    chk("haz2_lives", int'(lives), 1);
    chk("haz2_pulse", int'(lifeLostPulse), 1);
    frames = 0;
    done = 0;
    for (int c = 0; c < 400 && !done; c++) begin
      tick(c[0], c == 21, 0, 0);
      if (c[0]) frames++;
      if (gameState == 2'd1) done = 1;
    end
    chk("inv_window_done", int'(done), 1);
    chk("inv_window_frames", frames, INVULN_FRAMES);
    chk("hit_in_inv_lives", int'(lives), 1);

    // Last life lost.
    tick(0, 1, 0, 0);
    chk("over_state", int'(gameState), 3);
    chk("over_lives", int'(lives), 0);
    chk("over_freeze", int'(freeze), 1);
    tick(1, 1, 1, 0);
    chk("over_hit_ignored", int'(score), 30);
    tick(0, 1, 0, 1);
    chk("restart_state", int'(gameState), 1);
    chk("restart_lives", int'(lives), 3);
    chk("restart_score", int'(score), 0);

    // Saturation over 100 gifts.
    gifts = 0;
    for (int i = 0; i < 100; i++) begin
      tick(0, 1, 1, 0);
      if (giftPulse) gifts++;
      if (i == 98) chk("score_990", int'(score), 990);
    end
    chk("score_sat", int'(score), 999);
    chk("gift_pulses", gifts, 100);

    // Reset during INVULN with 30 frames left.
    tick(0, 1, 0, 0);
    for (int i = 0; i < 30; i++) tick(1, 0, 0, 0);
    chk("pre_rst_state", int'(gameState), 2);
    mid_reset();
    tick(1, 1, 0, 0);
    chk("post_rst_state", int'(gameState), 0);
    chk("post_rst_lives", int'(lives), 3);

    // Random play against the model.
    for (int i = 0; i < 4000; i++) begin
      n = int'($urandom_range(0, 999));
      if (n == 0) mid_reset();
      tick($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
           1'($urandom), $urandom_range(0, 40) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
